// File: rtl/note_replayer.sv
// Playback sequencer: fetches recorded note words from the note RAM
// and re-creates active-low key presses at their recorded tick times.
module note_replayer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TIME_W = 13
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_W-1:0]     num_notes,
  input  logic [2+2*TIME_W-1:0] rd_data,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [2:0]            key_n,
  output logic [TIME_W-1:0]     replay_time,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DW = 2 + 2 * TIME_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_START,
    PLAY,
    ADVANCE,
    FINISH
  } state_t;

  state_t              state, state_d;
  logic                start_q;
  logic                start_edge;
  logic                rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [ADDR_W-1:0]   addr_inc;
  logic [2:0]          key_n_d;
  logic [TIME_W-1:0]   time_d;
  logic                busy_d;
  logic                done_d;
  logic                clr_time;
  logic [ADDR_W-1:0]   n_lat, n_lat_d;
  logic [1:0]          key_r, key_d;
  logic [TIME_W-1:0]   st_r, st_d;
  logic [TIME_W-1:0]   dur_r, dur_d;
  logic [TIME_W-1:0]   rem, rem_d;
  logic [2:0]          key_low;

  assign start_edge = start & ~start_q;
  assign addr_inc   = rd_addr + ADDR_W'(1);

  // Map the latched 2-bit key code onto the active-low {do,re,mi} bus.
  always_comb begin
    key_low = 3'b111;
    case (key_r)
      2'b01:   key_low = 3'b011;
      2'b10:   key_low = 3'b101;
      2'b11:   key_low = 3'b110;
      default: key_low = 3'b111;
    endcase
  end

  // Next-state and next-output logic; stop overrides everything while busy.
  always_comb begin
    state_d   = state;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    key_n_d   = key_n;
    busy_d    = busy;
    done_d    = 1'b0;
    n_lat_d   = n_lat;
    key_d     = key_r;
    st_d      = st_r;
    dur_d     = dur_r;
    rem_d     = rem;
    clr_time  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_edge && !stop) begin
          n_lat_d   = num_notes;
          clr_time  = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          if (num_notes == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        key_d = rd_data[DW-1 -: 2];
        st_d  = rd_data[2*TIME_W-1 -: TIME_W];
        dur_d = rd_data[TIME_W-1:0];
        if (rd_data[DW-1 -: 2] == 2'b00) begin
          state_d = ADVANCE;
        end else begin
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (replay_time >= st_r) begin
          state_d = PLAY;
          key_n_d = key_low;
          rem_d   = (dur_r == '0) ? TIME_W'(1) : dur_r;
        end
      end
      PLAY: begin
        if (tick) begin
          if (rem <= TIME_W'(1)) begin
            key_n_d = 3'b111;
            state_d = ADVANCE;
          end else begin
            rem_d = rem - TIME_W'(1);
          end
        end
      end
      ADVANCE: begin
        rd_addr_d = addr_inc;
        if (addr_inc == n_lat) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop && state != IDLE) begin
      state_d = IDLE;
      key_n_d = 3'b111;
      rd_en_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Replay clock: counts ticks while busy and sticks at all-ones.
  always_comb begin
    time_d = replay_time;
    if (clr_time) begin
      time_d = '0;
    end else if (busy && tick && replay_time != '1) begin
      time_d = replay_time + TIME_W'(1);
    end
  end

  // State, outputs and note registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      key_n       <= 3'b111;
      replay_time <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      n_lat       <= '0;
      key_r       <= 2'b00;
      st_r        <= '0;
      dur_r       <= '0;
      rem         <= '0;
    end else begin
      state       <= state_d;
      start_q     <= start;
      rd_en       <= rd_en_d;
      rd_addr     <= rd_addr_d;
      key_n       <= key_n_d;
      replay_time <= time_d;
      busy        <= busy_d;
      done        <= done_d;
      n_lat       <= n_lat_d;
      key_r       <= key_d;
      st_r        <= st_d;
      dur_r       <= dur_d;
      rem         <= rem_d;
    end
  end

endmodule

// File: tb/tb_note_replayer.sv
// Directed bench for note_replayer: RAM model, tick source,
// key-window monitor and immediate-assertion checks.
module tb_note_replayer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tick = 1'b0;
  logic        start;
  logic        stop;
  logic [12:0] num_notes;
  logic [27:0] rd_data = '0;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [2:0]  key_n;
  logic [12:0] replay_time;
  logic        busy;
  logic        done;

  note_replayer dut (
    .clk         (clk),
    .resetn      (resetn),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .num_notes   (num_notes),
    .rd_data     (rd_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .key_n       (key_n),
    .replay_time (replay_time),
    .busy        (busy),
    .done        (done)
  );

  always #10 clk = ~clk;

  logic [27:0] mem [16];

  // RAM model: q valid one clock after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[3:0]];
  end

  int tick_div = 16;
  int tcnt = 0;

  // Tick source: one-cycle strobe every tick_div clocks.
  always @(negedge clk) begin
    tcnt++;
    if (tcnt >= tick_div) tcnt = 0;
    tick = (tcnt == 0);
  end

  logic [2:0]  kprev = 3'b111;
  int          np = 0;
  int          nr = 0;
  int          nfetch = 0;
  int          ndone = 0;
  int          nbad = 0;
  logic [2:0]  press_k [16];
  int          press_t [16];
  int          rel_t [16];
  int          faddr [32];

  // Monitor: logs key windows, fetch addresses and done pulses.
  always @(negedge clk) begin
    if (key_n !== kprev) begin
      if (key_n === 3'b111) begin
        rel_t[nr % 16] = 32'(replay_time);
        nr++;
      end else begin
        if (kprev !== 3'b111) nbad++;
        if (!$onehot(~key_n)) nbad++;
        press_k[np % 16] = key_n;
        press_t[np % 16] = 32'(replay_time);
        np++;
      end
    end
    kprev = key_n;
    if (rd_en === 1'b1) begin
      faddr[nfetch % 32] = 32'(rd_addr);
      nfetch++;
    end
    if (done === 1'b1) ndone++;
  end

  int checks = 0;
  int passes = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input int n);
    num_notes = 13'(n);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int c = 0;
    while (done !== 1'b1 && c < max) begin
      cyc();
      c++;
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic wait_key(input logic [2:0] k, input int max,
                          input string tag);
    int c = 0;
    while (key_n !== k && c < max) begin
      cyc();
      c++;
    end
    chk(tag, 32'(key_n), 32'(k));
  endtask

  function automatic logic [27:0] w(input logic [1:0] k,
                                    input logic [12:0] t,
                                    input logic [12:0] d);
    return {k, t, d};
  endfunction

  int b, r, f, d;
  logic [2:0] ek [3];
  int et [3];

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    num_notes = '0;
    repeat (3) cyc();
    chk("rst rd_en", 32'(rd_en), 0);
    chk("rst rd_addr", 32'(rd_addr), 0);
    chk("rst key_n", 32'(key_n), 32'(3'b111));
    chk("rst time", 32'(replay_time), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    resetn = 1'b1;
    repeat (3) cyc();

    // single do note at t=5 for 3 ticks
    mem[0] = w(2'b01, 13'd5, 13'd3);
    b = np; r = nr; f = nfetch; d = ndone;
    go(1);
    chk("t1 busy", 32'(busy), 1);
    wait_done(400, "t1 done");
    cyc();
    chk("t1 busy off", 32'(busy), 0);
    chk("t1 presses", 32'(np - b), 1);
    chk("t1 key", 32'(press_k[b % 16]), 32'(3'b011));
    chk("t1 press t", 32'(press_t[b % 16]), 5);
    chk("t1 rel t", 32'(rel_t[r % 16]), 8);
    chk("t1 fetches", 32'(nfetch - f), 1);
    chk("t1 addr", 32'(faddr[f % 32]), 0);
    chk("t1 dones", 32'(ndone - d), 1);

    // do/re/mi at t=2,6,10 each 2 ticks
    mem[0] = w(2'b01, 13'd2, 13'd2);
    mem[1] = w(2'b10, 13'd6, 13'd2);
    mem[2] = w(2'b11, 13'd10, 13'd2);
    ek[0] = 3'b011; ek[1] = 3'b101; ek[2] = 3'b110;
    et[0] = 2; et[1] = 6; et[2] = 10;
    b = np; r = nr; f = nfetch; d = ndone;
    go(3);
    wait_done(1000, "t2 done");
    cyc();
    chk("t2 presses", 32'(np - b), 3);
    chk("t2 fetches", 32'(nfetch - f), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2 key", 32'(press_k[(b + i) % 16]), 32'(ek[i]));
      chk("t2 press t", 32'(press_t[(b + i) % 16]), 32'(et[i]));
      chk("t2 rel t", 32'(rel_t[(r + i) % 16]), 32'(et[i] + 2));
      chk("t2 addr", 32'(faddr[(f + i) % 32]), 32'(i));
    end
    chk("t2 dones", 32'(ndone - d), 1);

    // empty recording
    b = np; f = nfetch; d = ndone;
    go(0);
    chk("t3 done", 32'(done), 1);
    cyc();
    chk("t3 busy off", 32'(busy), 0);
    chk("t3 key", 32'(key_n), 32'(3'b111));
    chk("t3 no fetch", 32'(nfetch - f), 0);
    chk("t3 no press", 32'(np - b), 0);
    chk("t3 dones", 32'(ndone - d), 1);

    // zero duration, no-key word, start in the past
    mem[0] = w(2'b10, 13'd3, 13'd0);
    mem[1] = w(2'b00, 13'd7, 13'd7);
    mem[2] = w(2'b11, 13'd1, 13'd4);
    b = np; r = nr; f = nfetch;
    go(3);
    wait_done(1000, "t4 done");
    cyc();
    chk("t4 presses", 32'(np - b), 2);
    chk("t4 fetches", 32'(nfetch - f), 3);
    chk("t4 re key", 32'(press_k[b % 16]), 32'(3'b101));
    chk("t4 re press", 32'(press_t[b % 16]), 3);
    chk("t4 re rel", 32'(rel_t[r % 16]), 4);
    chk("t4 mi key", 32'(press_k[(b + 1) % 16]), 32'(3'b110));
    chk("t4 mi press", 32'(press_t[(b + 1) % 16]), 4);
    chk("t4 mi rel", 32'(rel_t[(r + 1) % 16]), 8);
    chk("t4 addr2", 32'(faddr[(f + 2) % 32]), 2);

    // stop during note 2
    mem[0] = w(2'b01, 13'd2, 13'd2);
    mem[1] = w(2'b10, 13'd6, 13'd2);
    mem[2] = w(2'b11, 13'd10, 13'd2);
    d = ndone;
    go(3);
    wait_key(3'b101, 600, "t5 reach re");
    stop = 1'b1;
    cyc();
    chk("t5 key off", 32'(key_n), 32'(3'b111));
    chk("t5 busy off", 32'(busy), 0);
    chk("t5 rd_en off", 32'(rd_en), 0);
    stop = 1'b0;
    repeat (40) cyc();
    chk("t5 idle key", 32'(key_n), 32'(3'b111));
    chk("t5 idle busy", 32'(busy), 0);
    chk("t5 no done", 32'(ndone - d), 0);

    // asynchronous reset mid-replay
    go(3);
    wait_key(3'b011, 400, "t6 reach do");
    resetn = 1'b0;
    #1;
    chk("t6 key", 32'(key_n), 32'(3'b111));
    chk("t6 busy", 32'(busy), 0);
    chk("t6 time", 32'(replay_time), 0);
    chk("t6 rd_en", 32'(rd_en), 0);
    cyc();
    resetn = 1'b1;
    repeat (2) cyc();

    // saturation: note at the last representable tick
    tick_div = 1;
    mem[0] = w(2'b11, 13'h1FFF, 13'd2);
    b = np; r = nr; d = ndone;
    go(1);
    wait_key(3'b110, 9000, "t7 reach mi");
    chk("t7 press t", 32'(press_t[b % 16]), 32'h1FFF);
    wait_done(100, "t7 done");
    chk("t7 sat time", 32'(replay_time), 32'h1FFF);
    chk("t7 rel t", 32'(rel_t[r % 16]), 32'h1FFF);
    cyc();
    chk("t7 dones", 32'(ndone - d), 1);
    chk("t7 one-hot", 32'(nbad), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
